// File: rtl/gpio_in_filter.sv
// gpio_in_filter: synchronise raw pad levels, debounce per pin, and flag debounced edges as sticky interrupts.
module gpio_in_filter #(
  parameter int NUM_IO      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16,
  parameter int DB_CYCLES   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IO-1:0] pin_i,
  input  logic [NUM_IO-1:0] en_i,
  input  logic [NUM_IO-1:0] rise_en_i,
  input  logic [NUM_IO-1:0] fall_en_i,
  input  logic [NUM_IO-1:0] irq_clr_i,
  output logic [NUM_IO-1:0] io_pin_o,
  output logic [NUM_IO-1:0] edge_pend_o,
  output logic              irq_o
);
  typedef enum logic {STABLE, COUNT} state_e;
  localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DB_CYCLES - 1);
  logic [NUM_IO-1:0]   sync_q [SYNC_STAGES];
  state_e              st_q   [NUM_IO];
  logic [DB_CNT_W-1:0] cnt_q  [NUM_IO];
  logic [NUM_IO-1:0]   io_q, pend_q, s, diff, upd, ev, io_d, pend_d;
  always_comb begin
    s    = sync_q[SYNC_STAGES-1];
    diff = s ^ io_q;
    for (int i = 0; i < NUM_IO; i++)
      upd[i] = en_i[i] && st_q[i] == COUNT && diff[i] && cnt_q[i] == LAST;
    io_d   = io_q ^ upd;
    ev     = upd & ((s & rise_en_i) | (~s & fall_en_i));
    pend_d = ev | (pend_q & ~irq_clr_i);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < NUM_IO; i++) begin
        st_q[i]  <= STABLE;
        cnt_q[i] <= '0;
      end
      io_q   <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      io_q   <= io_d;
      pend_q <= pend_d;
      // Any return to the held level, a disable, or a completed count drops back to STABLE.
      for (int i = 0; i < NUM_IO; i++) begin
        if (!en_i[i] || !diff[i] || upd[i]) begin
          st_q[i]  <= STABLE;
          cnt_q[i] <= '0;
        end else if (st_q[i] == STABLE) begin
          st_q[i]  <= COUNT;
          cnt_q[i] <= DB_CNT_W'(1);
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end
  assign io_pin_o    = io_q;
  assign edge_pend_o = pend_q;
  assign irq_o       = |pend_q;
endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed and random stimulus, expected outputs queued per edge and checked by a monitor.
module tb_gpio_in_filter;
  localparam int N  = 2;
  localparam int SS = 2;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] pin_i = '0, en_i = '1, rise_en_i = '0, fall_en_i = '0, irq_clr_i = '0;
  logic [N-1:0] io_pin_o, edge_pend_o;
  logic irq_o;

  gpio_in_filter #(.NUM_IO(N), .SYNC_STAGES(SS), .DB_CNT_W(16), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .pin_i(pin_i), .en_i(en_i), .rise_en_i(rise_en_i),
    .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i), .io_pin_o(io_pin_o),
    .edge_pend_o(edge_pend_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] io;
    logic [N-1:0] pend;
    logic         irq;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference: pad samples age through a history; a pin's level changes once the
  // synced value has disagreed with it for DB consecutive enabled edges.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_io = '0, m_pend = '0;
  int run[N];

  task automatic model_edge();
    logic [N-1:0] s;
    logic ev;
    if (!rst) begin
      m_io = '0;
      m_pend = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
      hist.delete();
      for (int k = 0; k < SS; k++) hist.push_back('0);
    end else begin
      s = hist[SS-1];
      for (int i = 0; i < N; i++) begin
        ev = 1'b0;
        if (en_i[i] && s[i] != m_io[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            m_io[i] = s[i];
            ev = s[i] ? rise_en_i[i] : fall_en_i[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
        m_pend[i] = ev | (m_pend[i] & ~irq_clr_i[i]);
      end
      hist.push_front(pin_i);
      void'(hist.pop_back());
    end
    sb.push_back('{io: m_io, pend: m_pend, irq: |m_pend});
  endtask

  task automatic step(input logic r, input logic [N-1:0] p, input logic [N-1:0] en,
                      input logic [N-1:0] re, input logic [N-1:0] fe, input logic [N-1:0] clr);
    @(negedge clk);
    #1;
    rst = r; pin_i = p; en_i = en; rise_en_i = re; fall_en_i = fe; irq_clr_i = clr;
    model_edge();
  endtask

  task automatic hold(input int n, input logic [N-1:0] p, input logic [N-1:0] re, input logic [N-1:0] fe);
    for (int k = 0; k < n; k++) step(1'b1, p, en_i, re, fe, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (io_pin_o !== e.io || edge_pend_o !== e.pend || irq_o !== e.irq) begin
        n_err++;
        $display("FAIL outputs @%0t: io=%b pend=%b irq=%b, expected io=%b pend=%b irq=%b",
                 $time, io_pin_o, edge_pend_o, irq_o, e.io, e.pend, e.irq);
      end
    end
  end

  initial begin
    logic [N-1:0] p, en, re, fe, clr;
    logic r;
    for (int k = 0; k < SS; k++) hist.push_back('0);
    for (int i = 0; i < N; i++) run[i] = 0;
    for (int k = 0; k < 3; k++) step(1'b0, 2'b11, '1, '1, '1, '0);
    step(1'b1, 2'b00, '1, 2'b01, 2'b00, '0);
    hold(8, 2'b01, 2'b01, 2'b00);
    step(1'b1, 2'b01, '1, 2'b01, 2'b00, 2'b01);
    hold(2, 2'b01, 2'b01, 2'b00);
    hold(8, 2'b00, 2'b01, 2'b00);
    hold(3, 2'b01, 2'b11, 2'b11);
    hold(8, 2'b00, 2'b11, 2'b11);
    for (int k = 0; k < 6; k++) step(1'b1, {(k != 1), 1'b0}, '1, 2'b11, 2'b11, '0);
    hold(8, 2'b10, 2'b11, 2'b11);
    hold(8, 2'b11, 2'b11, 2'b11);
    hold(5, 2'b10, 2'b11, 2'b11);
    step(1'b1, 2'b10, '1, 2'b11, 2'b11, 2'b01);
    hold(3, 2'b10, 2'b11, 2'b11);
    step(1'b1, 2'b10, '1, 2'b11, 2'b11, 2'b11);
    for (int k = 0; k < 10; k++) step(1'b1, {1'b1, k[0]}, 2'b10, 2'b11, 2'b11, '0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'b00, 2'b10, 2'b11, 2'b11, '0);
    step(1'b0, 2'b00, '1, 2'b11, 2'b11, '0);
    step(1'b0, 2'b00, '1, 2'b11, 2'b11, '0);
    hold(10, 2'b00, 2'b11, 2'b11);
    p = '0; en = '1; re = '1; fe = '1;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(499) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) p[i] = ~p[i];
        if ($urandom_range(49) == 0) en[i] = ~en[i];
      end
      if ($urandom_range(99) == 0) begin
        re = N'($urandom);
        fe = N'($urandom);
      end
      clr = ($urandom_range(9) == 0) ? N'($urandom) : '0;
      step(r, p, en, re, fe, clr);
    end
    hold(2, p, re, fe);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
